// File: rtl/i2s_tx_sequencer_pkg.sv
// Shared types, frame width and the slot-justification helper for the I2S transmit sequencer.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int FRAME_W = 64;

  // MSB-justify a sample (zero-extended in 'sample') inside a slot_w-bit slot.
  function automatic logic [FRAME_W/2-1:0] make_slot(input logic [FRAME_W/2-1:0] sample,
                                                      input int                  sample_w,
                                                      input int                  slot_w);
    logic [FRAME_W/2-1:0] mask;
    mask = {(FRAME_W/2){1'b1}} >> (FRAME_W/2 - sample_w);
    return (sample & mask) << (slot_w - sample_w);
  endfunction

endpackage

// File: rtl/i2s_tx_sequencer_if.sv
// Stereo sample handshake between the synth mixer (master) and the I2S sequencer (slave).
interface i2s_tx_sequencer_if #(
  parameter int SAMPLE_W = 24
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_left;
  logic [SAMPLE_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input  s_ready);
  modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);
endinterface

// File: rtl/i2s_tx_sequencer_frame_shreg.sv
// Frame shift register: sync clear, parallel load (wins over shift), zero-fill left shift, MSB out.
module i2s_frame_shreg
  import i2s_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         sclk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  output logic         msb
);

  logic [W-1:0] q;

  // NOTE: clocked state is always written with <= so every register samples pre-edge values.
  always_ff @(posedge sclk) begin
    if (Reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: LRCLK edge detect, one-sample buffer, frame load/shift, underrun and framing monitors.
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32
) (
  input  logic                sclk,
  input  logic                Reset,
  input  logic                lrclk,
  i2s_tx_sequencer_if.slave   mix,
  output logic                sdata,
  output logic                frame_start,
  output logic [15:0]         underrun_cnt,
  output logic                framing_err
);

  localparam int FW    = 2 * SLOT_W;
  localparam int CNT_W = $clog2(FW);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FW - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SLOT_W - 1);

  state_t              state_q, state_d;
  logic                lr_q;
  logic                fall, rise;
  logic                buf_valid;
  logic [SAMPLE_W-1:0] buf_left, buf_right;
  logic                accept;
  logic                underrun;
  logic [CNT_W-1:0]    bit_cnt;
  logic [FRAME_W/2-1:0] slot_l, slot_r;
  logic [FW-1:0]       load_word;

  assign fall        = lr_q & ~lrclk;
  assign rise        = ~lr_q & lrclk;
  assign mix.s_ready = ~buf_valid | (fall & buf_valid);
  assign accept      = mix.s_valid & mix.s_ready;
  assign underrun    = fall & ~buf_valid & (state_q == RUN);

  assign slot_l    = make_slot((FRAME_W/2)'(buf_left),  SAMPLE_W, SLOT_W);
  assign slot_r    = make_slot((FRAME_W/2)'(buf_right), SAMPLE_W, SLOT_W);
  assign load_word = buf_valid ? {slot_l[SLOT_W-1:0], slot_r[SLOT_W-1:0]} : '0;

  always_ff @(posedge sclk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: assigning the default first means no path leaves state_d unassigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && fall) state_d = RUN;
  end

  always_ff @(posedge sclk) begin
    if (Reset) begin
      lr_q         <= 1'b1;
      buf_valid    <= 1'b0;
      bit_cnt      <= '0;
      frame_start  <= 1'b0;
      underrun_cnt <= '0;
      framing_err  <= 1'b0;
    end else begin
      lr_q        <= lrclk;
      frame_start <= fall;

      // A fall consumes the buffer; an accept in the same cycle refills it for the next frame.
      if (accept)    buf_valid <= 1'b1;
      else if (fall) buf_valid <= 1'b0;

      if (fall)                                     bit_cnt <= '0;
      else if (state_q == RUN && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;

      if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;

      if (state_q == RUN && ((rise && bit_cnt != CNT_HALF) || (fall && bit_cnt != CNT_MAX)))
        framing_err <= 1'b1;
    end
  end

  // NOTE: the sample payload has no reset; buf_valid alone says whether it means anything.
  always_ff @(posedge sclk) begin
    if (accept) begin
      buf_left  <= mix.s_left;
      buf_right <= mix.s_right;
    end
  end

  i2s_frame_shreg #(.W(FW)) u_shreg (
    .sclk  (sclk),
    .Reset (Reset),
    .load  (fall),
    .din   (load_word),
    .shift ((state_q == RUN) & ~fall),
    .msb   (sdata)
  );

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench: frame-level reference model plus directed and randomized LRCLK/mixer stimulus.
module tb_i2s_tx_sequencer;

  localparam int SAMPLE_W = 24;
  localparam int SLOT_W   = 32;

  logic        sclk = 1'b0;
  logic        Reset;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic [15:0] underrun_cnt;
  logic        framing_err;

  i2s_tx_sequencer_if #(.SAMPLE_W(SAMPLE_W)) mix ();

  i2s_tx_sequencer #(.SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W)) dut (
    .sclk         (sclk),
    .Reset        (Reset),
    .lrclk        (lrclk),
    .mix          (mix.slave),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun_cnt (underrun_cnt),
    .framing_err  (framing_err)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // A stereo frame is left then right, each 24-bit sample followed by 8 zero pad bits.
  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  // ---------------- reference model (frame level) ----------------
  bit          cmp_en = 1'b0;
  bit          m_run, m_lr_prev, m_buf_v, m_acc, m_ferr, m_fs;
  logic [23:0] m_buf_l, m_buf_r;
  logic [63:0] m_word;
  int          m_k;     // position in the current frame: k-th cycle after the loading fall
  int          m_urun;

  always @(posedge sclk) begin : model
    bit fall, rise, acc;
    if (Reset) begin
      m_run     <= 1'b0;
      m_lr_prev <= 1'b1;
      m_buf_v   <= 1'b0;
      m_word    <= '0;
      m_k       <= 1000;
      m_urun    <= 0;
      m_ferr    <= 1'b0;
      m_fs      <= 1'b0;
      m_acc     <= 1'b0;
      cmp_en    <= 1'b1;
    end else begin
      fall = m_lr_prev && !lrclk;
      rise = !m_lr_prev && lrclk;
      acc  = mix.s_valid && (!m_buf_v || fall);
      m_acc     <= acc;
      m_lr_prev <= lrclk;
      m_fs      <= fall;
      if (m_run && ((rise && m_k != SLOT_W) || (fall && m_k < 2 * SLOT_W))) m_ferr <= 1'b1;
      if (fall) begin
        m_word <= m_buf_v ? frame_of(m_buf_l, m_buf_r) : 64'h0;
        m_k    <= 1;
        m_run  <= 1'b1;
        if (m_run && !m_buf_v && m_urun < 65535) m_urun <= m_urun + 1;
      end else if (m_k < 1000) begin
        m_k <= m_k + 1;
      end
      if (acc) begin
        m_buf_v <= 1'b1;
        m_buf_l <= mix.s_left;
        m_buf_r <= mix.s_right;
      end else if (fall) begin
        m_buf_v <= 1'b0;
      end
    end
  end

  always @(negedge sclk) begin : compare
    logic exp_sdata;
    logic exp_rdy;
    if (cmp_en) begin
      exp_sdata = (m_k >= 1 && m_k <= 64) ? m_word[64 - m_k] : 1'b0;
      exp_rdy   = !m_buf_v || (m_lr_prev && !lrclk);
      check("sdata",        64'(sdata),        64'(exp_sdata));
      check("frame_start",  64'(frame_start),  64'(m_fs));
      check("underrun_cnt", 64'(underrun_cnt), 64'(m_urun));
      check("framing_err",  64'(framing_err),  64'(m_ferr));
      check("s_ready",      64'(mix.s_ready),  64'(exp_rdy));
    end
  end

  // Collect the 64 serial bits that follow each frame_start.
  logic [63:0] cap_word;
  logic [63:0] last_frame = '0;
  int          cap_n = 0;

  always @(negedge sclk) begin
    if (frame_start) begin
      cap_word <= {63'b0, sdata};
      cap_n    <= 1;
    end else if (cap_n > 0 && cap_n < 64) begin
      cap_word <= {cap_word[62:0], sdata};
      cap_n    <= cap_n + 1;
      if (cap_n == 63) last_frame <= {cap_word[62:0], sdata};
    end
  end

  // ---------------- stimulus ----------------
  bit rnd_mix = 1'b0;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic drive_random();
    if (!mix.s_valid || m_acc) begin
      mix.s_valid = ($urandom_range(0, 2) != 0);
      mix.s_left  = 24'($urandom);
      mix.s_right = 24'($urandom);
    end
  endtask

  task automatic half(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      lrclk = lvl;
      if (rnd_mix) drive_random();
      tick();
    end
  endtask

  task automatic full_rest();
    half(31, 1'b0);
    half(32, 1'b1);
    half(1, 1'b0);
  endtask

  initial begin
    Reset       = 1'b1;
    lrclk       = 1'b1;
    mix.s_valid = 1'b0;
    mix.s_left  = '0;
    mix.s_right = '0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_sdata",  64'(sdata),        64'd0);
    check("rst_ready",  64'(mix.s_ready),  64'd1);
    check("rst_urun",   64'(underrun_cnt), 64'd0);
    check("rst_ferr",   64'(framing_err),  64'd0);
    check("rst_fs",     64'(frame_start),  64'd0);

    // Sample buffered before the first boundary.
    mix.s_valid = 1'b1;
    mix.s_left  = 24'hABCDEF;
    mix.s_right = 24'h123456;
    tick();
    mix.s_valid = 1'b0;
    check("t1_ready_full", 64'(mix.s_ready), 64'd0);
    half(3, 1'b1);
    half(32, 1'b0);
    half(32, 1'b1);
    check("t1_urun", 64'(underrun_cnt), 64'd0);
    check("t1_ferr", 64'(framing_err),  64'd0);

    // Second boundary with nothing buffered.
    half(1, 1'b0);
    check("t1_frame", last_frame, 64'hABCDEF00_12345600);
    check("t2_urun",  64'(underrun_cnt), 64'd1);
    check("t2_fs",    64'(frame_start),  64'd1);
    half(31, 1'b0);
    half(20, 1'b1);
    check("t2_ready", 64'(mix.s_ready), 64'd1);

    // Back-to-back samples A then B; B accepted on the boundary.
    mix.s_valid = 1'b1;
    mix.s_left  = 24'h7FFFFF;
    mix.s_right = 24'h800001;
    half(1, 1'b1);
    check("t3_ready_a", 64'(mix.s_ready), 64'd0);
    mix.s_left  = 24'h000001;
    mix.s_right = 24'hFEDCBA;
    half(11, 1'b1);
    half(1, 1'b0);
    mix.s_valid = 1'b0;
    check("t2_frame",   last_frame, 64'h0);
    check("t3_urun",    64'(underrun_cnt), 64'd1);
    check("t3_ready_b", 64'(mix.s_ready), 64'd0);
    full_rest();
    check("t3_frame_a", last_frame, 64'h7FFFFF00_80000100);
    full_rest();
    check("t3_frame_b", last_frame, 64'h00000100_FEDCBA00);
    check("t3_urun2",   64'(underrun_cnt), 64'd2);

    // Early fall after 40 bits.
    half(31, 1'b0);
    half(8, 1'b1);
    check("t4_ferr_pre", 64'(framing_err), 64'd0);
    half(1, 1'b0);
    check("t4_ferr",     64'(framing_err), 64'd1);
    check("t4_reload",   64'(frame_start), 64'd1);
    full_rest();
    check("t4_sticky",   64'(framing_err), 64'd1);

    // Reset in the middle of a frame.
    half(20, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t5_sdata", 64'(sdata),        64'd0);
    check("t5_ready", 64'(mix.s_ready),  64'd1);
    check("t5_urun",  64'(underrun_cnt), 64'd0);
    check("t5_ferr",  64'(framing_err),  64'd0);
    half(1, 1'b0);
    check("t5_idle_fall", 64'(underrun_cnt), 64'd0);
    half(9, 1'b0);
    half(32, 1'b1);
    half(1, 1'b0);
    check("t5_first_urun", 64'(underrun_cnt), 64'd1);

    // Sample arrives exactly on a boundary with an empty buffer.
    half(31, 1'b0);
    half(32, 1'b1);
    mix.s_valid = 1'b1;
    mix.s_left  = 24'h5A5A5A;
    mix.s_right = 24'hC3C3C3;
    half(1, 1'b0);
    mix.s_valid = 1'b0;
    check("t6_urun",  64'(underrun_cnt), 64'd2);
    check("t6_ready", 64'(mix.s_ready),  64'd0);
    full_rest();
    check("t6_zero_frame", last_frame, 64'h0);
    check("t6_urun_hold",  64'(underrun_cnt), 64'd2);
    full_rest();
    check("t6_frame", last_frame, 64'h5A5A5A00_C3C3C300);

    // Randomized mixer traffic with occasional irregular LRCLK halves and resets.
    rnd_mix = 1'b1;
    repeat (40) begin
      half(($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 44)) : 32, 1'b0);
      half(($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 44)) : 32, 1'b1);
      if ($urandom_range(0, 15) == 0) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
      end
    end
    rnd_mix     = 1'b0;
    mix.s_valid = 1'b0;
    half(70, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
